// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver:
// active-high hex font table, segment bit positions and scan FSM states.
package seg7_pkg;

  // Segment bit positions within the 7-bit segment bus.
  localparam int unsigned SEG_A = 32'd0;
  localparam int unsigned SEG_B = 32'd1;
  localparam int unsigned SEG_C = 32'd2;
  localparam int unsigned SEG_D = 32'd3;
  localparam int unsigned SEG_E = 32'd4;
  localparam int unsigned SEG_F = 32'd5;
  localparam int unsigned SEG_G = 32'd6;

  // Active-high font {g,f,e,d,c,b,a} for hex digits 0-9, A, b, C, d, E, F.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Per-slot scan phase: dead-time first, then the digit is driven.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } seg7_state_e;

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble to active-high 7-segment decoder.
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_on
);

  // Table lookup from the shared font.
  always_comb begin
    seg_on = FONT[nib];
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed NUM_DIGITS hex 7-segment display driver with refresh
// prescaler, dead-time blanking, per-digit blanking, decimal points and
// frame-boundary (tear-free) value commit.
// Optional: define SEG7_LZB_EN to add leading-zero blanking at commit.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GHOST_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    pending,
  output logic                    frame_strobe
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]                 presc_r;
  logic [IW-1:0]                 idx_r;
  seg7_state_e                   state_r;
  seg7_state_e                   state_s;
  logic                          slot_wrap_s;
  logic                          commit_s;

  logic [NUM_DIGITS-1:0][3:0]    pend_val_r;
  logic [NUM_DIGITS-1:0]         pend_dp_r;
  logic [NUM_DIGITS-1:0]         pend_blank_r;
  logic                          pend_flag_r;
  logic [NUM_DIGITS-1:0][3:0]    act_val_r;
  logic [NUM_DIGITS-1:0]         act_dp_r;
  logic [NUM_DIGITS-1:0]         act_blank_r;
  logic [NUM_DIGITS-1:0]         blank_next_s;
  logic                          strobe_r;

  logic [3:0]                    nib_s;
  logic [6:0]                    font_s;
  logic [6:0]                    seg_s;
  logic                          dp_s;
  logic [NUM_DIGITS-1:0]         dig_s;
  logic [NUM_DIGITS-1:0]         onehot_s;
  logic [6:0]                    seg_r;
  logic                          dp_r;
  logic [NUM_DIGITS-1:0]         dig_r;

`ifdef SEG7_LZB_EN
  // Digit i (i>=1) is dark when it and every higher nibble are zero.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [NUM_DIGITS-1:0][3:0] v);
    logic zero_above;
    lzb_mask   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (v[i] == 4'h0);
      lzb_mask[i] = zero_above;
    end
  endfunction
`endif

  // Slot/frame boundary detection and scan FSM next state.
  always_comb begin
    slot_wrap_s = (presc_r == PW'(REFRESH_DIV - 1));
    commit_s    = slot_wrap_s && (idx_r == IW'(NUM_DIGITS - 1)) && pend_flag_r;
    state_s     = state_r;
    if (slot_wrap_s) begin
      state_s = BLANK;
    end else if (presc_r == PW'(GHOST_CYC - 1)) begin
      state_s = DRIVE;
    end else begin
      state_s = state_r;
    end
  end

  // Blank mask taken into the active set at commit.
  always_comb begin
`ifdef SEG7_LZB_EN
    blank_next_s = pend_blank_r | lzb_mask(pend_val_r);
`else
    blank_next_s = pend_blank_r;
`endif
  end

  // Prescaler, digit index and FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= '0;
      state_r <= BLANK;
    end else begin
      state_r <= state_s;
      if (slot_wrap_s) begin
        presc_r <= '0;
        idx_r   <= (idx_r == IW'(NUM_DIGITS - 1)) ? '0 : idx_r + IW'(1);
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Pending capture on load and active commit at the frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val_r   <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= '0;
      pend_flag_r  <= 1'b0;
      act_val_r    <= '0;
      act_dp_r     <= '0;
      act_blank_r  <= '0;
      strobe_r     <= 1'b0;
    end else begin
      strobe_r <= commit_s;
      if (commit_s) begin
        act_val_r   <= pend_val_r;
        act_dp_r    <= pend_dp_r;
        act_blank_r <= blank_next_s;
      end
      // A load on the commit cycle refills pending after the old contents move out.
      if (load) begin
        pend_val_r   <= value;
        pend_dp_r    <= dp_in;
        pend_blank_r <= blank_en;
        pend_flag_r  <= 1'b1;
      end else if (commit_s) begin
        pend_flag_r  <= 1'b0;
      end
    end
  end

  seg7_hex_font u_font (
    .nib    (nib_s),
    .seg_on (font_s)
  );

  // Select the current digit and form polarity-adjusted output values.
  always_comb begin
    nib_s    = act_val_r[idx_r];
    onehot_s = '0;
    onehot_s[idx_r] = 1'b1;
    if ((state_r == DRIVE) && !act_blank_r[idx_r]) begin
      seg_s = (SEG_ACTIVE_LOW != 0) ? ~font_s : font_s;
      dp_s  = (SEG_ACTIVE_LOW != 0) ? ~act_dp_r[idx_r] : act_dp_r[idx_r];
      dig_s = (DIG_ACTIVE_LOW != 0) ? ~onehot_s : onehot_s;
    end else begin
      seg_s = SEG_OFF;
      dp_s  = DP_OFF;
      dig_s = DIG_OFF;
    end
  end

  // Output registers: one cycle behind the state/index they reflect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r <= SEG_OFF;
      dp_r  <= DP_OFF;
      dig_r <= DIG_OFF;
    end else begin
      seg_r <= seg_s;
      dp_r  <= dp_s;
      dig_r <= dig_s;
    end
  end

  assign seg          = seg_r;
  assign dp           = dp_r;
  assign dig_sel      = dig_r;
  assign pending      = pend_flag_r;
  assign frame_strobe = strobe_r;

endmodule
